// File: rtl/seq_det_pkg.sv
// Shared types and limits for the parameterised serial pattern detector.
package seq_det_pkg;

  localparam int unsigned W_MIN = 2;
  localparam int unsigned W_MAX = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_e;

  function automatic int unsigned fill_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_det_param_cnt.sv
// Saturating up-counter with synchronous clear; used for the optional match count.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, increments stop at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_det_param.sv
// Serial W-bit pattern detector with loadable pattern and overlap control.
// Optional saturating match counter is built when SEQ_DET_CNT_EN is defined.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int unsigned   W           = 4,
  parameter logic [W-1:0]  DEFAULT_PAT = {W{1'b1}},
  parameter int unsigned   CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_valid,
  input  logic             x,
  input  logic             ovl,
  input  logic             pat_load,
  input  logic [W-1:0]     pat_in,
  output logic             z
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int unsigned    FW        = fill_width(W);
  localparam logic [FW-1:0]  FILL_FULL = FW'(W);
  localparam logic [FW-1:0]  FILL_ONE  = FW'(1);

  if ((W < W_MIN) || (W > W_MAX) || (CNT_W < 1)) begin : g_param_check
    $error("seq_det_param: W or CNT_W out of range");
  end

  state_e          state_q;
  state_e          state_d;
  logic [W-2:0]    hist_q;
  logic [W-2:0]    hist_d;
  logic [FW-1:0]   fill_q;
  logic [FW-1:0]   fill_d;
  logic [W-1:0]    pat_q;
  logic [W-1:0]    pat_d;
  logic            z_q;
  logic            z_d;

  logic            accept_s;
  logic [W-1:0]    cand_s;
  logic [FW-1:0]   fill_nxt_s;
  logic            full_nxt_s;
  logic            match_s;

  // A load cycle swallows any serial bit presented with it.
  assign accept_s   = x_valid & ~pat_load;
  assign cand_s     = {hist_q, x};
  assign fill_nxt_s = (fill_q == FILL_FULL) ? FILL_FULL : (fill_q + FILL_ONE);
  assign full_nxt_s = (fill_nxt_s == FILL_FULL);
  assign match_s    = accept_s & full_nxt_s & (cand_s == pat_q);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEFAULT_PAT;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      z_q     <= z_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (pat_load) begin
      state_d = IDLE;
    end else if (accept_s) begin
      case (state_q)
        IDLE, FILL: begin
          if (!full_nxt_s) begin
            state_d = FILL;
          end else if (match_s && !ovl) begin
            state_d = IDLE;
          end else begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          if (match_s && !ovl) begin
            state_d = IDLE;
          end else begin
            state_d = ARMED;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Datapath and output decode; returning to IDLE always restarts from empty.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    z_d    = 1'b0;
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
      z_d    = 1'b0;
    end else if (accept_s) begin
      z_d = match_s;
      if (state_d == IDLE) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = cand_s[W-2:0];
        fill_d = fill_nxt_s;
      end
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
  end

  assign z = z_q;

`ifdef SEQ_DET_CNT_EN
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match_s),
    .clr (pat_load),
    .cnt (match_cnt)
  );
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench for seq_det_param (W=4); match count checked when SEQ_DET_CNT_EN is defined.
module tb_seq_det_param;

  localparam int W     = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             x_valid;
  logic             x;
  logic             ovl;
  logic             pat_load;
  logic [W-1:0]     pat_in;
  logic             z;
`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] match_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;
  int p0;

  // reference model state
  logic [W-1:0] m_pat = 4'hF;
  logic [W-1:0] m_sh  = 4'h0;
  int           m_run = 0;
  int           m_cnt = 0;
  logic         exp_q[$];

  seq_det_param #(
    .W           (W),
    .DEFAULT_PAT (4'hF),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .x_valid   (x_valid),
    .x         (x),
    .ovl       (ovl),
    .pat_load  (pat_load),
    .pat_in    (pat_in)
`ifdef SEQ_DET_CNT_EN
    ,
    .match_cnt (match_cnt)
`endif
    ,
    .z         (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle, predict z and the count, then compare after the edge.
  task automatic step(input logic r, input logic xv, input logic xb, input logic ov,
                      input logic pl, input logic [W-1:0] pi);
    logic exp_z;
    logic got;
    rst = r; x_valid = xv; x = xb; ovl = ov; pat_load = pl; pat_in = pi;
    exp_z = 1'b0;
    if (r) begin
      m_pat = 4'hF; m_sh = 4'h0; m_run = 0; m_cnt = 0;
    end else if (pl) begin
      m_pat = pi; m_sh = 4'h0; m_run = 0; m_cnt = 0;
    end else if (xv) begin
      m_sh = {m_sh[W-2:0], xb};
      if (m_run < W) m_run++;
      if ((m_run == W) && (m_sh == m_pat)) begin
        exp_z = 1'b1;
        if (m_cnt < (2 ** CNT_W) - 1) m_cnt++;
        if (!ov) begin
          m_run = 0; m_sh = 4'h0;
        end
      end
    end
    exp_q.push_back(exp_z);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = exp_q.pop_front();
      chk("z", {31'd0, z}, {31'd0, got});
    end
    if (z) pulses++;
`ifdef SEQ_DET_CNT_EN
    chk("match_cnt", {24'd0, match_cnt}, m_cnt);
`endif
  endtask

  task automatic ones(input int n, input logic ov);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, ov, 1'b0, 4'h0);
  endtask

  task automatic send_bits(input logic [6:0] bits, input int n, input logic ov);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i], ov, 1'b0, 4'h0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    rst = 1'b1; x_valid = 1'b0; x = 1'b0; ovl = 1'b0; pat_load = 1'b0; pat_in = 4'h0;
    do_reset();
    do_reset();
    chk("reset_z", {31'd0, z}, 32'd0);

    // eight ones, overlapping
    p0 = pulses; ones(8, 1'b1);
    chk("ovl1_pulses", pulses - p0, 32'd5);

    // eight ones, non-overlapping
    do_reset();
    p0 = pulses; ones(8, 1'b0);
    chk("ovl0_pulses", pulses - p0, 32'd2);

    // loaded pattern 1011 with stream 1011011
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1011);
    p0 = pulses; send_bits(7'b1011011, 7, 1'b1);
    chk("pat1011_ovl1_pulses", pulses - p0, 32'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011);
    p0 = pulses; send_bits(7'b1011011, 7, 1'b0);
    chk("pat1011_ovl0_pulses", pulses - p0, 32'd1);

    // valid gaps do not break a sequence
    do_reset();
    p0 = pulses;
    ones(2, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    ones(2, 1'b1);
    chk("gap_pulses", pulses - p0, 32'd1);

    // load mid-sequence discards the coincident bit
    do_reset();
    p0 = pulses;
    ones(3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF);
    ones(3, 1'b1);
    chk("load_discard_pulses", pulses - p0, 32'd0);
    ones(1, 1'b1);
    chk("load_then4_pulses", pulses - p0, 32'd1);

    // reset mid-sequence discards progress
    do_reset();
    p0 = pulses;
    ones(3, 1'b1);
    do_reset();
    ones(3, 1'b1);
    chk("rst_discard_pulses", pulses - p0, 32'd0);
    ones(1, 1'b1);
    chk("rst_then4_pulses", pulses - p0, 32'd1);

    // randomised traffic with occasional loads and resets
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)));
    end

`ifdef SEQ_DET_CNT_EN
    // counter saturation
    do_reset();
    ones(270, 1'b1);
    chk("cnt_saturated", {24'd0, match_cnt}, 32'd255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_det_param.md
SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 SHALL have parameter W, default 4, meaning pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter DEFAULT_PAT, default all-ones of width W, meaning pattern loaded at reset.
REQ-003 SHALL have parameter CNT_W, default 8, meaning match-counter width.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port x_valid, input, 1, high when x carries a serial bit this cycle.
REQ-007 SHALL have port x, input, 1, serial data bit.
REQ-008 SHALL have port ovl, input, 1, 1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port pat_load, input, 1, loads pat_in as the new pattern.
REQ-010 SHALL have port pat_in, input, W, new pattern; bit W-1 is the first bit expected.
REQ-011 SHALL have port z, output, 1, registered one-cycle match pulse.
REQ-012 SHALL have port match_cnt, output, CNT_W, saturating match count (present only with SEQ_DET_CNT_EN).

Function
REQ-013 SHALL accept a bit only on a clk edge where x_valid=1 and pat_load=0; otherwise history, fill and pattern hold.
REQ-014 SHALL form cand = {hist[W-2:0], x} and fill_nxt = min(fill+1, W) for each accepted bit.
REQ-015 SHALL declare match when a bit is accepted, fill_nxt==W and cand==pattern.
REQ-016 SHALL register z: z=1 for exactly the cycle after a match edge, else 0 (Mealy decision, registered output, latency 1).
REQ-017 SHALL run a 3-state FSM on fill: IDLE (fill=0) -> FILL (0<fill<W) -> ARMED (fill=W).
REQ-018 ARMED with ovl=1 and a match SHALL remain ARMED, keeping the shifted history.
REQ-019 ARMED with ovl=0 and a match SHALL go to IDLE, clearing hist and fill.
REQ-020 SHALL sample ovl per accepted bit; a change applies to the match coinciding with that bit.
REQ-021 pat_load=1 SHALL update pattern, clear hist/fill (IDLE), discard any simultaneous x bit, and force z=0 next cycle.
REQ-022 x_valid gaps SHALL NOT break a sequence; matching counts accepted bits only.

Reset
REQ-023 rst SHALL set z=0, hist=0, fill=0 (IDLE), pattern=DEFAULT_PAT, match_cnt=0; rst has priority over pat_load and x_valid.
REQ-024 rst asserted mid-sequence SHALL discard partial progress; a full W fresh bits are then needed to match.

Configuration
REQ-025 With SEQ_DET_CNT_EN defined, match_cnt SHALL increment on every match, saturate at all-ones, and clear on rst or pat_load.
REQ-026 Without SEQ_DET_CNT_EN, the port match_cnt and the counter logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-027 A shared package seq_det_pkg SHALL hold the FSM state typedef (IDLE, FILL, ARMED) and the W range limits.
REQ-028 Counter logic SHALL be a sub-module sat_counter (parameter CNT_W; ports inc, clr, cnt), instantiated only under SEQ_DET_CNT_EN.

Verification
REQ-029 W=4, default 1111, ovl=1, eight consecutive 1s -> z high after bits 4,5,6,7,8; match_cnt=5.
REQ-030 Same stream, ovl=0 -> z high after bits 4 and 8 only; match_cnt=2.
REQ-031 Load 1011, stream 1011011, ovl=1 -> z after bits 4 and 7; with ovl=0 -> z after bit 4 only.
REQ-032 Default 1111, bits 1,1,gap(x_valid=0 for 3 cycles),1,1 -> single z pulse after the 4th valid bit.
REQ-033 After 3 ones, assert pat_load(1111) together with x_valid=1, x=1 -> bit discarded, z=0, match_cnt=0; 4 more ones are needed to match.
REQ-034 After 3 ones, pulse rst, then send 1 -> z stays 0; a match appears only after 4 post-reset ones.
